// File: rtl/pong_match_ctrl.sv
// Round/score sequencer for the pong game: drives the ball/paddle datapath controls,
// keeps both scores, detects the winner and drives the two indicator LEDs.
module pong_match_ctrl #(
   parameter int WIN_SCORE    = 7,
   parameter int SCORE_W      = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90,
   parameter int SPEED_STEP   = 5,
   parameter int BLINK_SH     = 3
) (
   input  logic               clk_pix,
   input  logic               rst_n,
   input  logic               frame,
   input  logic               start,
   input  logic               lft_col,
   input  logic               rgt_col,
   input  logic               p_hit,
   output logic               round_init,
   output logic               serve_dir,
   output logic               motion_en,
   output logic               human_en,
   output logic               speed_inc,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic [1:0]         winner,
   output logic [2:0]         game_state,
   output logic               led_1,
   output logic               led_2
);

   localparam int FRM_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int FRM_W   = $clog2(FRM_MAX + 1);
   localparam int HIT_W   = $clog2(SPEED_STEP + 1);
   localparam int BLK_W   = BLINK_SH + 1;

   localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
   localparam logic [FRM_W-1:0]   SERVE_LD = FRM_W'(SERVE_FRAMES);
   localparam logic [FRM_W-1:0]   POINT_LD = FRM_W'(POINT_FRAMES);
   localparam logic [FRM_W-1:0]   FRM_ONE  = FRM_W'(1);
   localparam logic [HIT_W-1:0]   HIT_LAST = HIT_W'(SPEED_STEP - 1);
   localparam logic [1:0]         WHO_NONE = 2'b00;
   localparam logic [1:0]         WHO_P1   = 2'b01;
   localparam logic [1:0]         WHO_P2   = 2'b10;

   typedef enum logic [2:0] {
      ST_ATTRACT   = 3'd0,
      ST_SERVE     = 3'd1,
      ST_PLAY      = 3'd2,
      ST_PAUSE     = 3'd3,
      ST_POINT     = 3'd4,
      ST_GAME_OVER = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] score_p1_q, score_p1_d;
   logic [SCORE_W-1:0] score_p2_q, score_p2_d;
   logic [1:0]         winner_q, winner_d;
   logic [1:0]         scorer_q, scorer_d;
   logic               serve_dir_q, serve_dir_d;
   logic [FRM_W-1:0]   frm_cnt_q, frm_cnt_d;
   logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
   logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
   logic               round_init_q, round_init_d;
   logic               speed_inc_q, speed_inc_d;
   logic               motion_en_q, motion_en_d;
   logic               human_en_q, human_en_d;
   logic               led_1_q, led_1_d;
   logic               led_2_q, led_2_d;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s >= WIN_S) ? s : s + SCORE_W'(1);
   endfunction

   always_ff @(posedge clk_pix) begin
      if (!rst_n) begin
         state_q      <= ST_ATTRACT;
         score_p1_q   <= '0;
         score_p2_q   <= '0;
         winner_q     <= WHO_NONE;
         scorer_q     <= WHO_NONE;
         serve_dir_q  <= 1'b0;
         frm_cnt_q    <= '0;
         hit_cnt_q    <= '0;
         blink_cnt_q  <= '0;
         round_init_q <= 1'b0;
         speed_inc_q  <= 1'b0;
         motion_en_q  <= 1'b1;
         human_en_q   <= 1'b0;
         led_1_q      <= 1'b0;
         led_2_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         score_p1_q   <= score_p1_d;
         score_p2_q   <= score_p2_d;
         winner_q     <= winner_d;
         scorer_q     <= scorer_d;
         serve_dir_q  <= serve_dir_d;
         frm_cnt_q    <= frm_cnt_d;
         hit_cnt_q    <= hit_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         round_init_q <= round_init_d;
         speed_inc_q  <= speed_inc_d;
         motion_en_q  <= motion_en_d;
         human_en_q   <= human_en_d;
         led_1_q      <= led_1_d;
         led_2_q      <= led_2_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      score_p1_d  = score_p1_q;
      score_p2_d  = score_p2_q;
      winner_d    = winner_q;
      scorer_d    = scorer_q;
      serve_dir_d = serve_dir_q;
      frm_cnt_d   = frm_cnt_q;
      hit_cnt_d   = hit_cnt_q;
      blink_cnt_d = blink_cnt_q;
      speed_inc_d = 1'b0;
      case (state_q)
         ST_ATTRACT: begin
            if (lft_col || rgt_col) hit_cnt_d = '0;
            if (start) begin
               score_p1_d  = '0;
               score_p2_d  = '0;
               winner_d    = WHO_NONE;
               scorer_d    = WHO_NONE;
               serve_dir_d = 1'b0;
               state_d     = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (frame) begin
               if (frm_cnt_q <= FRM_ONE) begin
                  frm_cnt_d = '0;
                  state_d   = ST_PLAY;
               end else begin
                  frm_cnt_d = frm_cnt_q - FRM_ONE;
               end
            end
         end
         ST_PLAY: begin
            if (frame && p_hit) begin
               if (hit_cnt_q >= HIT_LAST) begin
                  hit_cnt_d   = '0;
                  speed_inc_d = 1'b1;
               end else begin
                  hit_cnt_d = hit_cnt_q + HIT_W'(1);
               end
            end
            // Collisions outrank the pause button when both land together.
            if (lft_col && rgt_col) begin
               scorer_d = WHO_NONE;
               state_d  = ST_POINT;
            end else if (rgt_col) begin
               score_p1_d  = sat_inc(score_p1_q);
               scorer_d    = WHO_P1;
               serve_dir_d = 1'b0;
               state_d     = ST_POINT;
            end else if (lft_col) begin
               score_p2_d  = sat_inc(score_p2_q);
               scorer_d    = WHO_P2;
               serve_dir_d = 1'b1;
               state_d     = ST_POINT;
            end else if (start) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (start) state_d = ST_PLAY;
         end
         ST_POINT: begin
            if (frame) begin
               blink_cnt_d = blink_cnt_q + BLK_W'(1);
               if (frm_cnt_q <= FRM_ONE) begin
                  frm_cnt_d = '0;
                  if (scorer_q == WHO_P1 && score_p1_q == WIN_S) begin
                     winner_d = WHO_P1;
                     state_d  = ST_GAME_OVER;
                  end else if (scorer_q == WHO_P2 && score_p2_q == WIN_S) begin
                     winner_d = WHO_P2;
                     state_d  = ST_GAME_OVER;
                  end else begin
                     state_d = ST_SERVE;
                  end
               end else begin
                  frm_cnt_d = frm_cnt_q - FRM_ONE;
               end
            end
         end
         ST_GAME_OVER: begin
            if (start) begin
               score_p1_d  = '0;
               score_p2_d  = '0;
               winner_d    = WHO_NONE;
               scorer_d    = WHO_NONE;
               serve_dir_d = 1'b0;
               state_d     = ST_SERVE;
            end
         end
         default: state_d = ST_ATTRACT;
      endcase
      // Entry actions: timers reload and a new round clears the hit count.
      if (state_d != state_q) begin
         if (state_d == ST_SERVE) begin
            frm_cnt_d = SERVE_LD;
            hit_cnt_d = '0;
         end else if (state_d == ST_POINT) begin
            frm_cnt_d   = POINT_LD;
            blink_cnt_d = '0;
         end
      end
   end

   always_comb begin
      motion_en_d  = 1'b0;
      human_en_d   = 1'b1;
      led_1_d      = 1'b0;
      led_2_d      = 1'b0;
      round_init_d = ((state_d == ST_SERVE) && (state_q != ST_SERVE)) ||
                     ((state_q == ST_ATTRACT) && (state_d == ST_ATTRACT) && (lft_col || rgt_col));
      case (state_d)
         ST_ATTRACT: begin
            motion_en_d = 1'b1;
            human_en_d  = 1'b0;
         end
         ST_PLAY: motion_en_d = 1'b1;
         ST_POINT: begin
            led_1_d = (scorer_d == WHO_P1) && blink_cnt_d[BLINK_SH];
            led_2_d = (scorer_d == WHO_P2) && blink_cnt_d[BLINK_SH];
         end
         ST_GAME_OVER: begin
            led_1_d = (winner_d == WHO_P1);
            led_2_d = (winner_d == WHO_P2);
         end
         default: motion_en_d = 1'b0;
      endcase
   end

   assign round_init = round_init_q;
   assign serve_dir  = serve_dir_q;
   assign motion_en  = motion_en_q;
   assign human_en   = human_en_q;
   assign speed_inc  = speed_inc_q;
   assign score_p1   = score_p1_q;
   assign score_p2   = score_p2_q;
   assign winner     = winner_q;
   assign game_state = state_q;
   assign led_1      = led_1_q;
   assign led_2      = led_2_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: short serve/point timers, WIN_SCORE=2.
module tb_pong_match_ctrl;

   logic       clk_pix;
   logic       rst_n;
   logic       frame;
   logic       start;
   logic       lft_col;
   logic       rgt_col;
   logic       p_hit;
   logic       round_init;
   logic       serve_dir;
   logic       motion_en;
   logic       human_en;
   logic       speed_inc;
   logic [3:0] score_p1;
   logic [3:0] score_p2;
   logic [1:0] winner;
   logic [2:0] game_state;
   logic       led_1;
   logic       led_2;

   int n_vec;
   int n_err;
   int spd_seen;

   pong_match_ctrl #(
      .WIN_SCORE   (2),
      .SCORE_W     (4),
      .SERVE_FRAMES(3),
      .POINT_FRAMES(20),
      .SPEED_STEP  (5),
      .BLINK_SH    (3)
   ) dut (
      .clk_pix   (clk_pix),
      .rst_n     (rst_n),
      .frame     (frame),
      .start     (start),
      .lft_col   (lft_col),
      .rgt_col   (rgt_col),
      .p_hit     (p_hit),
      .round_init(round_init),
      .serve_dir (serve_dir),
      .motion_en (motion_en),
      .human_en  (human_en),
      .speed_inc (speed_inc),
      .score_p1  (score_p1),
      .score_p2  (score_p2),
      .winner    (winner),
      .game_state(game_state),
      .led_1     (led_1),
      .led_2     (led_2)
   );

   initial clk_pix = 1'b0;
   always #5 clk_pix = ~clk_pix;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_pix);
      #1;
      if (speed_inc === 1'b1) spd_seen++;
   endtask

   // One idle cycle, then a frame tick; sampling lands just after the frame edge.
   task automatic frames(input int n, input logic hit);
      for (int i = 0; i < n; i++) begin
         tick();
         frame = 1'b1;
         p_hit = hit;
         tick();
         frame = 1'b0;
         p_hit = 1'b0;
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; spd_seen = 0;
      rst_n = 1'b0; frame = 1'b0; start = 1'b0;
      lft_col = 1'b0; rgt_col = 1'b0; p_hit = 1'b0;
      repeat (2) tick();
      chk_eq("rst_state", game_state, 0);
      chk_eq("rst_motion", motion_en, 1);
      chk_eq("rst_human", human_en, 0);
      chk_eq("rst_s1", score_p1, 0);
      chk_eq("rst_s2", score_p2, 0);
      chk_eq("rst_winner", winner, 0);
      chk_eq("rst_leds", {led_1, led_2}, 0);
      chk_eq("rst_ri", round_init, 0);
      rst_n = 1'b1;
      tick();

      rgt_col = 1'b1; tick(); rgt_col = 1'b0;
      chk_eq("att_ri", round_init, 1);
      chk_eq("att_state", game_state, 0);
      chk_eq("att_s1", score_p1, 0);
      tick();
      chk_eq("att_ri_off", round_init, 0);

      start = 1'b1; tick(); start = 1'b0;
      chk_eq("srv_state", game_state, 1);
      chk_eq("srv_ri", round_init, 1);
      chk_eq("srv_motion", motion_en, 0);
      chk_eq("srv_human", human_en, 1);
      tick();
      chk_eq("srv_ri_once", round_init, 0);
      frames(2, 1'b0);
      chk_eq("srv_wait", game_state, 1);
      frames(1, 1'b0);
      chk_eq("play_state", game_state, 2);
      chk_eq("play_motion", motion_en, 1);

      spd_seen = 0;
      frames(5, 1'b1);
      chk_eq("spd_at5", speed_inc, 1);
      frames(5, 1'b1);
      chk_eq("spd_at10", speed_inc, 1);
      tick();
      chk_eq("spd_total", spd_seen, 2);

      spd_seen = 0;
      frames(3, 1'b1);
      start = 1'b1; tick(); start = 1'b0;
      chk_eq("pause_state", game_state, 3);
      chk_eq("pause_motion", motion_en, 0);
      frames(2, 1'b1);
      rgt_col = 1'b1; tick(); rgt_col = 1'b0;
      chk_eq("pause_hold", game_state, 3);
      chk_eq("pause_s1", score_p1, 0);
      chk_eq("pause_spd", spd_seen, 0);
      start = 1'b1; tick(); start = 1'b0;
      chk_eq("resume", game_state, 2);

      start = 1'b1; rgt_col = 1'b1; tick(); start = 1'b0; rgt_col = 1'b0;
      chk_eq("pt_state", game_state, 4);
      chk_eq("pt_s1", score_p1, 1);
      chk_eq("pt_dir", serve_dir, 0);
      chk_eq("pt_motion", motion_en, 0);
      frames(7, 1'b0);
      chk_eq("blink7", led_1, 0);
      frames(1, 1'b0);
      chk_eq("blink8", led_1, 1);
      chk_eq("blink8_l2", led_2, 0);
      frames(7, 1'b0);
      chk_eq("blink15", led_1, 1);
      frames(1, 1'b0);
      chk_eq("blink16", led_1, 0);
      frames(3, 1'b0);
      chk_eq("pt_hold19", game_state, 4);
      frames(1, 1'b0);
      chk_eq("pt_to_srv", game_state, 1);
      chk_eq("pt_ri", round_init, 1);
      frames(3, 1'b0);
      chk_eq("play2", game_state, 2);

      spd_seen = 0;
      frames(4, 1'b1);
      chk_eq("hitclr4", spd_seen, 0);
      frames(1, 1'b1);
      chk_eq("hitclr5", speed_inc, 1);

      lft_col = 1'b1; tick(); lft_col = 1'b0;
      chk_eq("p2_state", game_state, 4);
      chk_eq("p2_s2", score_p2, 1);
      chk_eq("p2_s1", score_p1, 1);
      chk_eq("p2_dir", serve_dir, 1);
      frames(8, 1'b0);
      chk_eq("p2_leds", {led_1, led_2}, 1);
      frames(12, 1'b0);
      chk_eq("p2_srv", game_state, 1);
      frames(3, 1'b0);
      chk_eq("play3", game_state, 2);

      lft_col = 1'b1; rgt_col = 1'b1; tick(); lft_col = 1'b0; rgt_col = 1'b0;
      chk_eq("both_state", game_state, 4);
      chk_eq("both_scores", {score_p1, score_p2}, 8'h11);
      chk_eq("both_dir", serve_dir, 1);
      frames(8, 1'b0);
      chk_eq("both_leds", {led_1, led_2}, 0);
      frames(12, 1'b0);
      chk_eq("both_srv", game_state, 1);
      frames(3, 1'b0);
      chk_eq("play4", game_state, 2);

      rgt_col = 1'b1; tick(); rgt_col = 1'b0;
      chk_eq("win_s1", score_p1, 2);
      chk_eq("win_dir", serve_dir, 0);
      frames(20, 1'b0);
      chk_eq("go_state", game_state, 5);
      chk_eq("go_winner", winner, 1);
      chk_eq("go_leds", {led_1, led_2}, 2);
      chk_eq("go_motion", motion_en, 0);
      repeat (3) tick();
      chk_eq("go_solid", led_1, 1);
      start = 1'b1; tick(); start = 1'b0;
      chk_eq("restart_state", game_state, 1);
      chk_eq("restart_scores", {score_p1, score_p2}, 0);
      chk_eq("restart_winner", winner, 0);
      chk_eq("restart_ri", round_init, 1);
      chk_eq("restart_leds", {led_1, led_2}, 0);

      frames(3, 1'b0);
      chk_eq("play5", game_state, 2);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk_eq("mid_rst_state", game_state, 0);
      chk_eq("mid_rst_motion", motion_en, 1);
      chk_eq("mid_rst_human", human_en, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
